// File: rtl/calc_pkg.sv
// Shared encodings for the calculator entry path.
// Holds the state and operator enums used by the FSM and the bench.
package calc_pkg;

    localparam int DATA_W_DEF = 4;

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_OP  = 2'd1,
        S_B   = 2'd2,
        S_RES = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_XOR = 2'd3
    } op_t;

endpackage

// File: rtl/rise_edge_detect.sv
// Rising-edge detector for one debounced button level.
// Prev resets to 1 so a button held through reset never fires.
module rise_edge_detect (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Level,
    output logic o_Pulse
);

    logic r_Prev;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_Prev <= 1'b1;
        end else begin
            r_Prev <= i_Level;
        end
    end

    assign o_Pulse = i_Level & ~r_Prev;

endmodule

// File: rtl/calc_entry_fsm.sv
// Operand/operator entry FSM for the calculator.
// Steps A -> op -> B -> result and drives an 8-bit display value.
module calc_entry_fsm
    import calc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Btn_Inc,
    input  logic              i_Btn_Op,
    input  logic              i_Btn_Next,
    input  logic              i_Btn_Clr,
    output logic [7:0]        o_Display,
    output logic [1:0]        o_State,
    output logic [1:0]        o_Op,
    output logic              o_Result_Valid,
    output logic              o_Neg
);

    localparam int RES_W = 2 * DATA_W;

    logic w_Inc;
    logic w_OpP;
    logic w_Next;
    logic w_Clr;

    rise_edge_detect u_inc (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Level(i_Btn_Inc), .o_Pulse(w_Inc)
    );
    rise_edge_detect u_op (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Level(i_Btn_Op), .o_Pulse(w_OpP)
    );
    rise_edge_detect u_next (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Level(i_Btn_Next), .o_Pulse(w_Next)
    );
    rise_edge_detect u_clr (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Level(i_Btn_Clr), .o_Pulse(w_Clr)
    );

    state_t              r_State;
    op_t                 r_Op;
    logic [DATA_W-1:0]   r_A;
    logic [DATA_W-1:0]   r_B;
    logic [RES_W-1:0]    r_Result;
    logic                r_Neg;
    logic [7:0]          r_Display;
    logic                r_Valid;

    state_t              w_State;
    op_t                 w_Op;
    logic [DATA_W-1:0]   w_A;
    logic [DATA_W-1:0]   w_B;
    logic [RES_W-1:0]    w_Result;
    logic                w_Neg;
    logic [7:0]          w_Display;
    logic [RES_W-1:0]    w_AExt;
    logic [RES_W-1:0]    w_BExt;
    logic [RES_W-1:0]    w_Calc;

    assign w_AExt = {{DATA_W{1'b0}}, r_A};
    assign w_BExt = {{DATA_W{1'b0}}, r_B};

    always_comb begin
        w_Calc = '0;
        case (r_Op)
            OP_ADD:  w_Calc = w_AExt + w_BExt;
            OP_SUB:  w_Calc = w_AExt - w_BExt;
            OP_MUL:  w_Calc = w_AExt * w_BExt;
            default: w_Calc = w_AExt ^ w_BExt;
        endcase
    end

    // Clr beats Next beats Inc/Op; lower-priority pulses are dropped.
    always_comb begin
        w_State  = r_State;
        w_Op     = r_Op;
        w_A      = r_A;
        w_B      = r_B;
        w_Result = r_Result;
        w_Neg    = r_Neg;
        if (w_Clr) begin
            w_State  = S_A;
            w_Op     = OP_ADD;
            w_A      = '0;
            w_B      = '0;
            w_Result = '0;
            w_Neg    = 1'b0;
        end else if (w_Next) begin
            case (r_State)
                S_A:  w_State = S_OP;
                S_OP: w_State = S_B;
                S_B: begin
                    w_State  = S_RES;
                    w_Result = w_Calc;
                    w_Neg    = (r_Op == OP_SUB) && (r_A < r_B);
                end
                default: begin
                    w_State  = S_A;
                    w_A      = '0;
                    w_B      = '0;
                    w_Result = '0;
                    w_Neg    = 1'b0;
                end
            endcase
        end else begin
            case (r_State)
                S_A:  if (w_Inc) w_A = r_A + 1'b1;
                S_OP: if (w_Inc || w_OpP) w_Op = op_t'(r_Op + 2'd1);
                S_B:  if (w_Inc) w_B = r_B + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_Display = 8'h00;
        case (w_State)
            S_A:     w_Display = 8'(w_A);
            S_OP:    w_Display = {6'b0, w_Op};
            S_B:     w_Display = 8'(w_B);
            default: w_Display = 8'(w_Result);
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_State   <= S_A;
            r_Op      <= OP_ADD;
            r_A       <= '0;
            r_B       <= '0;
            r_Result  <= '0;
            r_Neg     <= 1'b0;
            r_Display <= 8'h00;
            r_Valid   <= 1'b0;
        end else begin
            r_State   <= w_State;
            r_Op      <= w_Op;
            r_A       <= w_A;
            r_B       <= w_B;
            r_Result  <= w_Result;
            r_Neg     <= w_Neg;
            r_Display <= w_Display;
            r_Valid   <= (w_State == S_RES);
        end
    end

    assign o_Display      = r_Display;
    assign o_State        = r_State;
    assign o_Op           = r_Op;
    assign o_Result_Valid = r_Valid;
    assign o_Neg          = r_Neg;

endmodule
